// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller. Drives a probe into an external
// combinational magnitude comparator and binary-searches for the value that
// the comparator reports as equal to its target.
module sar_search_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StDone
  } state_e;

  localparam logic [WIDTH-1:0] MaxVal     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] FirstProbe = {1'b0, {(WIDTH-1){1'b1}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             error_q, error_d;

  // Midpoints of the narrowed ranges, one bit wider so lo+hi cannot wrap.
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] dn_sum;
  logic           flags_ok;

  // Candidate next probes for the two search directions.
  always_comb begin
    up_sum   = {1'b0, probe_q} + {{WIDTH{1'b0}}, 1'b1} + {1'b0, hi_q};
    dn_sum   = {1'b0, lo_q} + {1'b0, probe_q} - {{WIDTH{1'b0}}, 1'b1};
    flags_ok = $onehot({cmp_gt, cmp_eq, cmp_lt});
  end

  // Next-state and output-register logic; all values hold by default.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probe_d  = probe_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    error_d  = error_q;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          lo_d    = '0;
          hi_d    = MaxVal;
          probe_d = FirstProbe;
          busy_d  = 1'b1;
          found_d = 1'b0;
          error_d = 1'b0;
          state_d = StSample;
        end
      end

      StSample: begin
        if (!flags_ok) begin
          error_d  = 1'b1;
          found_d  = 1'b0;
          result_d = probe_q;
          state_d  = StDone;
        end else if (cmp_eq) begin
          found_d  = 1'b1;
          result_d = probe_q;
          state_d  = StDone;
        end else if (cmp_gt) begin
          if (probe_q == hi_q) begin
            // Range exhausted: only an inconsistent comparator gets here.
            found_d  = 1'b0;
            result_d = probe_q;
            state_d  = StDone;
          end else begin
            lo_d    = probe_q + 1'b1;
            probe_d = WIDTH'(up_sum >> 1);
          end
        end else begin
          if (probe_q == lo_q) begin
            found_d  = 1'b0;
            result_d = probe_q;
            state_d  = StDone;
          end else begin
            hi_d    = probe_q - 1'b1;
            probe_d = WIDTH'(dn_sum >> 1);
          end
        end
        if (state_d == StDone) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end

      StDone: begin
        // Single-cycle completion pulse; start is not looked at here.
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= MaxVal;
      probe_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      error_q  <= error_d;
    end
  end

  assign probe  = probe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign error  = error_q;
  assign result = result_q;

endmodule
